cmd_proc: RTL and testbench

Command sequencer between the UART command receiver and the navigation/solve datapath of MazeRunner. Decodes each 16-bit command from the remote link, starts the matching operation (gyro calibration, heading change, forward move with speed ramp, or autonomous solve), waits for completion, then pulses a response request so the top level returns 0xA5. Owns the forward-speed profile and the move-termination rules (wall ahead, left/right opening).

---
 rtl/maze_pkg.sv | 36 +++
 rtl/spd_ramp.sv | 55 +++++
 rtl/cmd_proc.sv | 206 ++++++++++++++++++++
 tb/tb_cmd_proc.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared opcode/state encodings and forward-speed ramp constants
// for the MazeRunner command sequencer.
package maze_pkg;

   // Command opcodes carried in cmd[15:13]
   typedef enum logic [2:0] {
      OP_CAL   = 3'b000,
      OP_HDNG  = 3'b001,
      OP_MOVE  = 3'b010,
      OP_SOLVE = 3'b011
   } opcode_e;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CAL   = 3'd1,
      ST_HDNG  = 3'd2,
      ST_MV_UP = 3'd3,
      ST_MV_DN = 3'd4,
      ST_SOLVE = 3'd5
   } state_e;

   // Speed added per heading sample while ramping up (doubled on ramp-down)
   localparam logic [10:0] RAMP_STEP_FAST = 11'h020;
   localparam logic [10:0] RAMP_STEP_SLOW = 11'h003;

   // Pick the ramp step for simulation-speed or real-hardware builds
   function automatic logic [10:0] ramp_step(input bit fast_sim);
      if (fast_sim) begin
         return RAMP_STEP_FAST;
      end else begin
         return RAMP_STEP_SLOW;
      end
   endfunction

endpackage

// File: rtl/spd_ramp.sv
// spd_ramp: forward-speed register. Increments by STEP up to MAX_SPD,
// decrements by 2*STEP down to zero, clear has priority over both.
module spd_ramp #(
   parameter logic [10:0] STEP    = 11'h020,
   parameter logic [10:0] MAX_SPD = 11'h2A0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        inc_i,
   input  logic        dec_i,
   output logic [10:0] spd_o
);

   logic [10:0] spd_q;
   logic [10:0] spd_d;
   logic [11:0] sum_s;
   logic [11:0] dec_amt_s;

   // Next speed: sums are 12 bits wide so the clamp sees any carry out
   always_comb begin
      sum_s     = {1'b0, spd_q} + {1'b0, STEP};
      dec_amt_s = {STEP, 1'b0};
      spd_d     = spd_q;
      if (clr_i) begin
         spd_d = 11'h000;
      end else if (inc_i) begin
         if (sum_s > {1'b0, MAX_SPD}) begin
            spd_d = MAX_SPD;
         end else begin
            spd_d = sum_s[10:0];
         end
      end else if (dec_i) begin
         if ({1'b0, spd_q} <= dec_amt_s) begin
            spd_d = 11'h000;
         end else begin
            spd_d = spd_q - dec_amt_s[10:0];
         end
      end else begin
         spd_d = spd_q;
      end
   end

   // Speed register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spd_q <= 11'h000;
      end else begin
         spd_q <= spd_d;
      end
   end

   assign spd_o = spd_q;

endmodule

// File: rtl/cmd_proc.sv
// cmd_proc: decodes remote-link commands, sequences calibration, heading,
// move and solve operations, and requests a response when each finishes.
module cmd_proc
   import maze_pkg::*;
#(
   parameter bit          FAST_SIM = 1'b1,
   parameter logic [10:0] MAX_SPD  = 11'h2A0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd,
   input  logic        cmd_rdy,
   output logic        clr_cmd_rdy,
   input  logic        cal_done,
   input  logic        at_hdng,
   input  logic        hdng_vld,
   input  logic        frwrd_opn,
   input  logic        lft_opn,
   input  logic        rght_opn,
   input  logic        sol_cmplt,
   output logic        strt_cal,
   output logic        in_cal,
   output logic        strt_hdng,
   output logic [11:0] dsrd_hdng,
   output logic [10:0] frwrd_spd,
   output logic        cmd_md,
   output logic        lft_aff,
   output logic        send_resp
);

   localparam logic [10:0] STEP = ramp_step(FAST_SIM);

   state_e      state_q;
   logic        clr_cmd_rdy_q;
   logic        strt_cal_q;
   logic        in_cal_q;
   logic        strt_hdng_q;
   logic [11:0] dsrd_hdng_q;
   logic        cmd_md_q;
   logic        lft_aff_q;
   logic        send_resp_q;
   logic        stp_lft_q;
   logic        stp_rght_q;
   logic [1:0]  hdng_cnt_q;
   logic        lft_prev_q;
   logic        rght_prev_q;

   logic        lft_rise_s;
   logic        rght_rise_s;
   logic        stop_s;
   logic        ramp_clr_s;
   logic        ramp_inc_s;
   logic        ramp_dec_s;
   logic [10:0] spd_s;
   logic        unused_cmd_s;

   // cmd[12] carries no meaning for any opcode
   assign unused_cmd_s = cmd[12];

   // Move termination and ramp controls; a stop wins over a same-cycle sample
   always_comb begin
      lft_rise_s  = lft_opn & ~lft_prev_q;
      rght_rise_s = rght_opn & ~rght_prev_q;
      stop_s      = ~frwrd_opn | (stp_lft_q & lft_rise_s) | (stp_rght_q & rght_rise_s);
      ramp_clr_s  = (state_q == ST_IDLE);
      ramp_inc_s  = 1'b0;
      ramp_dec_s  = 1'b0;
      if (state_q == ST_MV_UP) begin
         ramp_inc_s = hdng_vld & ~stop_s;
      end else if (state_q == ST_MV_DN) begin
         ramp_dec_s = hdng_vld;
      end else begin
         ramp_inc_s = 1'b0;
         ramp_dec_s = 1'b0;
      end
   end

   // Previous side-opening levels, tracked every cycle so openings already
   // present when a move begins are not mistaken for new ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_prev_q  <= 1'b0;
         rght_prev_q <= 1'b0;
      end else begin
         lft_prev_q  <= lft_opn;
         rght_prev_q <= rght_opn;
      end
   end

   // Command sequencer FSM with registered pulses and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         clr_cmd_rdy_q <= 1'b0;
         strt_cal_q    <= 1'b0;
         in_cal_q      <= 1'b0;
         strt_hdng_q   <= 1'b0;
         dsrd_hdng_q   <= 12'h000;
         cmd_md_q      <= 1'b1;
         lft_aff_q     <= 1'b0;
         send_resp_q   <= 1'b0;
         stp_lft_q     <= 1'b0;
         stp_rght_q    <= 1'b0;
         hdng_cnt_q    <= 2'd0;
      end else begin
         clr_cmd_rdy_q <= 1'b0;
         strt_cal_q    <= 1'b0;
         strt_hdng_q   <= 1'b0;
         send_resp_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // cmd_rdy is still high in the cycle clr_cmd_rdy is out; skip it
               if (cmd_rdy && !clr_cmd_rdy_q) begin
                  clr_cmd_rdy_q <= 1'b1;
                  case (opcode_e'(cmd[15:13]))
                     OP_CAL: begin
                        strt_cal_q <= 1'b1;
                        in_cal_q   <= 1'b1;
                        state_q    <= ST_CAL;
                     end
                     OP_HDNG: begin
                        dsrd_hdng_q <= cmd[11:0];
                        strt_hdng_q <= 1'b1;
                        hdng_cnt_q  <= 2'd0;
                        state_q     <= ST_HDNG;
                     end
                     OP_MOVE: begin
                        stp_lft_q  <= cmd[1];
                        stp_rght_q <= cmd[0];
                        state_q    <= ST_MV_UP;
                     end
                     OP_SOLVE: begin
                        lft_aff_q <= cmd[0];
                        cmd_md_q  <= 1'b0;
                        state_q   <= ST_SOLVE;
                     end
                     default: begin
                        state_q <= ST_IDLE;
                     end
                  endcase
               end
            end
            ST_CAL: begin
               if (cal_done) begin
                  in_cal_q    <= 1'b0;
                  send_resp_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_HDNG: begin
               // at_hdng may still reflect the old heading for two cycles
               if (hdng_cnt_q != 2'd2) begin
                  hdng_cnt_q <= hdng_cnt_q + 2'd1;
               end else if (at_hdng) begin
                  send_resp_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_MV_UP: begin
               if (stop_s) begin
                  state_q <= ST_MV_DN;
               end
            end
            ST_MV_DN: begin
               if (spd_s == 11'h000) begin
                  send_resp_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_SOLVE: begin
               if (sol_cmplt) begin
                  cmd_md_q    <= 1'b1;
                  send_resp_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   spd_ramp #(
      .STEP    (STEP),
      .MAX_SPD (MAX_SPD)
   ) u_spd_ramp (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (ramp_clr_s),
      .inc_i (ramp_inc_s),
      .dec_i (ramp_dec_s),
      .spd_o (spd_s)
   );

   assign clr_cmd_rdy = clr_cmd_rdy_q;
   assign strt_cal    = strt_cal_q;
   assign in_cal      = in_cal_q;
   assign strt_hdng   = strt_hdng_q;
   assign dsrd_hdng   = dsrd_hdng_q;
   assign frwrd_spd   = spd_s;
   assign cmd_md      = cmd_md_q;
   assign lft_aff     = lft_aff_q;
   assign send_resp   = send_resp_q;

endmodule

// File: tb/tb_cmd_proc.sv
// tb_cmd_proc: directed test of cmd_proc; inputs change and outputs are
// sampled on the falling clock edge.
module tb_cmd_proc;

   logic        clk;
   logic        rst_n;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        cal_done;
   logic        at_hdng;
   logic        hdng_vld;
   logic        frwrd_opn;
   logic        lft_opn;
   logic        rght_opn;
   logic        sol_cmplt;
   logic        strt_cal;
   logic        in_cal;
   logic        strt_hdng;
   logic [11:0] dsrd_hdng;
   logic [10:0] frwrd_spd;
   logic        cmd_md;
   logic        lft_aff;
   logic        send_resp;

   int total;
   int bad;

   cmd_proc #(
      .FAST_SIM (1'b1),
      .MAX_SPD  (11'h2A0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .cal_done    (cal_done),
      .at_hdng     (at_hdng),
      .hdng_vld    (hdng_vld),
      .frwrd_opn   (frwrd_opn),
      .lft_opn     (lft_opn),
      .rght_opn    (rght_opn),
      .sol_cmplt   (sol_cmplt),
      .strt_cal    (strt_cal),
      .in_cal      (in_cal),
      .strt_hdng   (strt_hdng),
      .dsrd_hdng   (dsrd_hdng),
      .frwrd_spd   (frwrd_spd),
      .cmd_md      (cmd_md),
      .lft_aff     (lft_aff),
      .send_resp   (send_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a command; it is sampled on the next rising edge
   task automatic issue(input logic [15:0] c);
      cmd     = c;
      cmd_rdy = 1'b1;
      tick();
   endtask

   // One-cycle heading-sample pulse
   task automatic pulse_hv();
      hdng_vld = 1'b1;
      tick();
      hdng_vld = 1'b0;
   endtask

   int cnt_a;
   int cnt_b;
   int cnt_c;
   logic [10:0] exp_spd;

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      cmd       = 16'h0000;
      cmd_rdy   = 1'b0;
      cal_done  = 1'b0;
      at_hdng   = 1'b0;
      hdng_vld  = 1'b0;
      frwrd_opn = 1'b1;
      lft_opn   = 1'b0;
      rght_opn  = 1'b0;
      sol_cmplt = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_spd",  32'(frwrd_spd), 32'h0);
      chk("rst_cmd_md", 32'(cmd_md), 32'h1);
      chk("rst_lft_aff", 32'(lft_aff), 32'h0);
      chk("rst_dsrd", 32'(dsrd_hdng), 32'h0);
      chk("rst_pulses", 32'({clr_cmd_rdy, strt_cal, strt_hdng, send_resp, in_cal}), 32'h0);
      rst_n = 1'b1;
      tick();

      // CAL: strt_cal single pulse, in_cal held until cal_done
      issue(16'h0000);
      chk("cal_clr", 32'(clr_cmd_rdy), 32'h1);
      chk("cal_strt", 32'(strt_cal), 32'h1);
      chk("cal_in_cal0", 32'(in_cal), 32'h1);
      cmd_rdy = 1'b0;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         cnt_a += int'(in_cal);
         cnt_b += int'(strt_cal);
         cnt_c += int'(send_resp);
      end
      chk("cal_in_cal_cnt", 32'(cnt_a), 32'd100);
      chk("cal_strt_extra", 32'(cnt_b), 32'd0);
      chk("cal_early_resp", 32'(cnt_c), 32'd0);
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0;
      chk("cal_resp", 32'(send_resp), 32'h1);
      chk("cal_in_cal_off", 32'(in_cal), 32'h0);
      chk("cal_cmd_md", 32'(cmd_md), 32'h1);
      tick();
      chk("cal_resp_once", 32'(send_resp), 32'h0);

      // HDNG 0x23FF: at_hdng raised after 50 clocks
      issue(16'h23FF);
      chk("hd_strt", 32'(strt_hdng), 32'h1);
      chk("hd_clr", 32'(clr_cmd_rdy), 32'h1);
      chk("hd_dsrd", 32'(dsrd_hdng), 32'h3FF);
      cmd_rdy = 1'b0;
      cnt_b = 0; cnt_c = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         cnt_b += int'(strt_hdng);
         cnt_c += int'(send_resp);
      end
      chk("hd_strt_extra", 32'(cnt_b), 32'd0);
      chk("hd_early_resp", 32'(cnt_c), 32'd0);
      at_hdng = 1'b1;
      tick();
      chk("hd_resp", 32'(send_resp), 32'h1);
      at_hdng = 1'b0;
      tick();
      chk("hd_resp_once", 32'(send_resp), 32'h0);

      // HDNG 0x2123 with at_hdng already high: ignored for two cycles
      at_hdng = 1'b1;
      issue(16'h2123);
      chk("hd2_dsrd", 32'(dsrd_hdng), 32'h123);
      cmd_rdy = 1'b0;
      tick();
      chk("hd2_wait1", 32'(send_resp), 32'h0);
      tick();
      chk("hd2_wait2", 32'(send_resp), 32'h0);
      tick();
      chk("hd2_resp", 32'(send_resp), 32'h1);
      at_hdng = 1'b0;
      tick();

      // MOVE 0x4000: ramp up by 0x20 to 0x2A0, hold, then down by 0x40
      issue(16'h4000);
      chk("mv_clr", 32'(clr_cmd_rdy), 32'h1);
      cmd_rdy = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         pulse_hv();
         exp_spd = (i >= 21) ? 11'h2A0 : 11'(i * 32);
         chk("mv_up_spd", 32'(frwrd_spd), 32'(exp_spd));
         tick(); tick(); tick();
      end
      // wall ahead and a heading sample together: no increment
      frwrd_opn = 1'b1;
      frwrd_opn = 1'b0;
      hdng_vld  = 1'b1;
      tick();
      hdng_vld  = 1'b0;
      frwrd_opn = 1'b1;
      chk("mv_stop_hold", 32'(frwrd_spd), 32'h2A0);
      tick();
      exp_spd = 11'h2A0;
      for (int k = 1; k <= 11; k++) begin
         pulse_hv();
         exp_spd = (k == 11) ? 11'h000 : 11'(11'h2A0 - 11'(k * 64));
         chk("mv_dn_spd", 32'(frwrd_spd), 32'(exp_spd));
         chk("mv_dn_noresp", 32'(send_resp), 32'h0);
         if (k < 11) begin
            tick(); tick(); tick();
         end
      end
      tick();
      chk("mv_resp", 32'(send_resp), 32'h1);
      tick();
      chk("mv_resp_once", 32'(send_resp), 32'h0);

      // MOVE 0x4002: stop on a new left opening only
      lft_opn = 1'b1;
      tick();
      issue(16'h4002);
      cmd_rdy = 1'b0;
      pulse_hv();
      pulse_hv();
      chk("lf_cont", 32'(frwrd_spd), 32'h040);
      rght_opn = 1'b1;
      tick();
      tick();
      pulse_hv();
      chk("lf_rght_ign", 32'(frwrd_spd), 32'h060);
      rght_opn = 1'b0;
      lft_opn  = 1'b0;
      tick();
      lft_opn  = 1'b1;
      tick();
      pulse_hv();
      chk("lf_dn1", 32'(frwrd_spd), 32'h020);
      pulse_hv();
      chk("lf_dn2", 32'(frwrd_spd), 32'h000);
      tick();
      chk("lf_resp", 32'(send_resp), 32'h1);
      lft_opn = 1'b0;
      tick();

      // SOLVE 0x6001 with a CAL command queued behind it
      issue(16'h6001);
      chk("sv_clr", 32'(clr_cmd_rdy), 32'h1);
      chk("sv_cmd_md", 32'(cmd_md), 32'h0);
      chk("sv_lft_aff", 32'(lft_aff), 32'h1);
      cmd_rdy = 1'b0;
      tick();
      issue(16'h0000);
      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         cnt_a += int'(clr_cmd_rdy) + int'(strt_cal) + int'(send_resp);
      end
      chk("sv_queue_held", 32'(cnt_a), 32'd0);
      sol_cmplt = 1'b1;
      tick();
      sol_cmplt = 1'b0;
      chk("sv_resp", 32'(send_resp), 32'h1);
      chk("sv_cmd_md1", 32'(cmd_md), 32'h1);
      tick();
      chk("sv_resp_once", 32'(send_resp), 32'h0);
      chk("sv_q_clr", 32'(clr_cmd_rdy), 32'h1);
      chk("sv_q_strt", 32'(strt_cal), 32'h1);
      cmd_rdy = 1'b0;
      cal_done = 1'b1;
      tick();
      cal_done = 1'b0;
      chk("sv_q_resp", 32'(send_resp), 32'h1);
      tick();

      // Illegal opcode: consumed, no response
      issue(16'hE000);
      chk("il_clr", 32'(clr_cmd_rdy), 32'h1);
      chk("il_strt", 32'({strt_cal, strt_hdng, in_cal}), 32'h0);
      cmd_rdy = 1'b0;
      cnt_c = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         cnt_c += int'(send_resp) + int'(clr_cmd_rdy);
      end
      chk("il_no_resp", 32'(cnt_c), 32'd0);

      // Reset during MV_UP
      issue(16'h4000);
      cmd_rdy = 1'b0;
      pulse_hv();
      pulse_hv();
      pulse_hv();
      chk("rm_spd", 32'(frwrd_spd), 32'h060);
      rst_n = 1'b0;
      #1;
      chk("rm_spd_clr", 32'(frwrd_spd), 32'h0);
      tick();
      rst_n = 1'b1;
      cnt_c = 0;
      for (int i = 0; i < 4; i++) begin
         pulse_hv();
         cnt_c += int'(send_resp);
      end
      chk("rm_no_resp", 32'(cnt_c), 32'd0);
      chk("rm_idle_spd", 32'(frwrd_spd), 32'h0);
      issue(16'h2005);
      chk("rm_idle_disp", 32'(strt_hdng), 32'h1);
      chk("rm_dsrd", 32'(dsrd_hdng), 32'h005);
      cmd_rdy = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
